// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle control unit
//
// Purpose: state enum, Op / ALUControl / cmd encodings, condition-code
//          constants and the data-processing cmd decoder used by
//          multicycle_control and cond_unit.
// Ports:   none (package).

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // valid: cmd is one of the four supported operations
    // arith: ADD/SUB, the only commands that may write C and V
    typedef struct packed {
        logic       valid;
        logic       arith;
        logic [1:0] alu_ctrl;
    } alu_dec_t;

    function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{valid: 1'b1, arith: 1'b0, alu_ctrl: ALU_ADD};
        case (cmd)
            CMD_ADD: begin d.alu_ctrl = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.alu_ctrl = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.alu_ctrl = ALU_AND;
            CMD_ORR: d.alu_ctrl = ALU_ORR;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flags register, condition evaluation, flag-write gating
//
// Purpose: holds the stored NZCV flags, evaluates Cond against them and
//          gates flag writes with the result.
// Config:  COND_EXEC_EN defined -> condition logic active;
//          undefined -> cond_ex tied to 1 (flags still update).
// Ports:
//   clk, reset      clock / async active-high reset
//   cond            instruction condition field
//   alu_flags       live ALU {N,Z,C,V}
//   flag_write_req  S=1 flag-setting op in an execute state
//   write_cv        op also writes C and V (ADD/SUB)
//   hold_en         capture cond_ex into cond_ex_held this cycle
//   flags           stored {N,Z,C,V}
//   cond_ex         live condition result on stored flags
//   cond_ex_held    condition result sampled before this instruction's flag update

import mc_pkg::*;

module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write_req,
    input  logic       write_cv,
    input  logic       hold_en,
    output logic [3:0] flags,
    output logic       cond_ex,
    output logic       cond_ex_held
);

    logic n, z, c, v;
    logic cond_met;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_met = 1'b0;
        case (cond)
            COND_EQ: cond_met = z;
            COND_NE: cond_met = ~z;
            COND_CS: cond_met = c;
            COND_CC: cond_met = ~c;
            COND_MI: cond_met = n;
            COND_PL: cond_met = ~n;
            COND_VS: cond_met = v;
            COND_VC: cond_met = ~v;
            COND_HI: cond_met = c & ~z;
            COND_LS: cond_met = ~(c & ~z);
            COND_GE: cond_met = (n == v);
            COND_LT: cond_met = (n != v);
            COND_GT: cond_met = ~z & (n == v);
            COND_LE: cond_met = ~(~z & (n == v));
            COND_AL: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

`ifdef COND_EXEC_EN
    assign cond_ex = cond_met;
`else
    // Every instruction executes; the evaluator result is deliberately ignored.
    assign cond_ex = cond_met | 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_write_req && cond_ex) begin
            flags[3:2] <= alu_flags[3:2];
            if (write_cv) begin
                flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    // The writeback state follows the flag-update edge, so it must use the
    // condition as evaluated on the flags from before that update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_held <= 1'b0;
        end else if (hold_en) begin
            cond_ex_held <= cond_ex;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle Moore control FSM with decoders
//
// Purpose: sequences each instruction through the control FSM, decodes the
//          ALU command and drives datapath mux selects and write enables.
// Config:  COND_EXEC_EN (in cond_unit) enables conditional execution.
// Ports:
//   clk, reset            clock / async active-high reset
//   Op, Funct, Rd, Cond   instruction fields
//   ALUFlags              live ALU {N,Z,C,V}
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc    mux selects
//   ImmSrc, RegSrc        Op-decoded selects
//   ALUControl            ALU operation
//   Flags                 stored NZCV

import mc_pkg::*;

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    state_t   state;
    state_t   next_state;
    alu_dec_t dec;
    logic     in_exec;
    logic     rd_is_pc;
    logic     cond_ex;
    logic     cond_ex_held;

    assign dec      = decode_cmd(Funct[4:1]);
    assign in_exec  = (state == S_EXECR) || (state == S_EXECI);
    assign rd_is_pc = (Rd == 4'd15);

    cond_unit u_cond (
        .clk            (clk),
        .reset          (reset),
        .cond           (Cond),
        .alu_flags      (ALUFlags),
        .flag_write_req (in_exec & Funct[0] & dec.valid),
        .write_cv       (dec.arith),
        .hold_en        (in_exec),
        .flags          (Flags),
        .cond_ex        (cond_ex),
        .cond_ex_held   (cond_ex_held)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = Op;
        RegSrc     = {Op == OP_MEM, Op == OP_BR};
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex & ~rd_is_pc;
                PCWrite   = cond_ex & rd_is_pc;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = dec.alu_ctrl;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dec.alu_ctrl;
            end
            S_ALUWB: begin
                RegWrite = cond_ex_held & dec.valid & ~rd_is_pc;
                PCWrite  = cond_ex_held & rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: ;
        endcase
        // Reset kills every write in the same cycle it rises.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd, Cond, ALUFlags;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] mflags;
    logic [15:0] dut_b;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
    );

    always #5 clk = ~clk;

    assign dut_b = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return (c == c) || (f == f);
`endif
    endfunction

    function automatic logic [15:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic adr, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] res,
                                       input logic [1:0] aluc, input logic [1:0] op);
        return {pcw, irw, rw, mw, adr, srca, srcb, res, op, op == 2'b01, op == 2'b10, aluc};
    endfunction

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge
    // of the next FETCH.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] cond,
                             input logic [3:0] aluf, input string name);
        logic [15:0] exp_q[$];
        logic        cex, valid, pc_dst, arith;
        logic [1:0]  aluc;
        logic [3:0]  cmd;
        check({name, " flags_pre"}, {12'd0, Flags}, {12'd0, mflags});
        Op = op; Funct = funct; Rd = rd; Cond = cond; ALUFlags = aluf;
        cex    = cond_holds(cond, mflags);
        cmd    = funct[4:1];
        pc_dst = (rd == 4'd15);
        valid  = 1'b1;
        arith  = 1'b0;
        aluc   = 2'b00;
        case (cmd)
            4'b0100: begin aluc = 2'b00; arith = 1'b1; end
            4'b0010: begin aluc = 2'b01; arith = 1'b1; end
            4'b0000: aluc = 2'b10;
            4'b1100: aluc = 2'b11;
            default: valid = 1'b0;
        endcase
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, op));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, op));
        case (op)
            2'b00: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, {1'b0, funct[5]}, 2'b00, aluc, op));
                exp_q.push_back(mk(cex && pc_dst, 0, cex && valid && !pc_dst, 0, 0, 0,
                                   2'b00, 2'b00, 2'b00, op));
            end
            2'b01: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, op));
                if (funct[0]) begin
                    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, op));
                    exp_q.push_back(mk(cex && pc_dst, 0, cex && !pc_dst, 0, 0, 0,
                                       2'b00, 2'b01, 2'b00, op));
                end else begin
                    exp_q.push_back(mk(0, 0, 0, cex, 1, 0, 2'b00, 2'b00, 2'b00, op));
                end
            end
            2'b10: exp_q.push_back(mk(cex, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, op));
            default: ;
        endcase
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            check($sformatf("%s c%0d", name, i), dut_b, exp_q[i]);
            @(posedge clk);
            @(negedge clk);
        end
        if (op == 2'b00 && funct[0] && cex && valid) begin
            mflags[3:2] = aluf[3:2];
            if (arith) mflags[1:0] = aluf[1:0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outs", dut_b, mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, Op));
        check("reset_flags", {12'd0, Flags}, 16'd0);
        @(negedge clk);
        reset  = 1'b0;
        mflags = 4'b0000;
    endtask

    initial begin
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd, cond, aluf;
        logic [3:0] cmds [4];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
        reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Cond = 4'd14; ALUFlags = 4'd0;
        mflags = 4'b0000;
        @(negedge clk);
        do_reset();

        run_instr(2'b00, 6'b001001, 4'd2, 4'hE, 4'b0110, "adds");
        check("adds_flags", {12'd0, Flags}, 16'h0006);

        do_reset();
        run_instr(2'b00, 6'b000001, 4'd3, 4'hE, 4'b1011, "ands");
        check("ands_flags", {12'd0, Flags}, 16'h0008);

        do_reset();
        run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, "beq_z0");
        run_instr(2'b00, 6'b000101, 4'd1, 4'hE, 4'b0100, "set_z");
        run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, "beq_z1");
        run_instr(2'b01, 6'b000001, 4'd15, 4'hE, 4'b0000, "ldr_pc");
        run_instr(2'b01, 6'b000000, 4'd4, 4'hF, 4'b0000, "str_nv");
        run_instr(2'b11, 6'b000000, 4'd4, 4'hE, 4'b0000, "undef");

        // Reset in the middle of a store with all flags set.
        run_instr(2'b00, 6'b001001, 4'd2, 4'hE, 4'b1111, "adds_all");
        check("flags_1111", {12'd0, Flags}, 16'h000F);
        Op = 2'b01; Funct = 6'b000000; Rd = 4'd3; Cond = 4'hE;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("memwr_pre", dut_b, mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01));
        reset = 1'b1;
        #1;
        check("memwr_rst_outs", dut_b, mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b01));
        check("memwr_rst_flags", {12'd0, Flags}, 16'd0);
        @(negedge clk);
        reset  = 1'b0;
        mflags = 4'b0000;
        run_instr(2'b00, 6'b101000, 4'd5, 4'hE, 4'b1111, "post_rst");

        for (int k = 0; k < 150; k++) begin
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            if ($urandom_range(0, 3) != 0) funct[4:1] = cmds[$urandom_range(0, 3)];
            rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
            aluf  = 4'($urandom);
            run_instr(op, funct, rd, cond, aluf, $sformatf("rnd%0d", k));
        end
        check("final_flags", {12'd0, Flags}, {12'd0, mflags});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
